shift_sample_capture: RTL

Parametrised, multi-channel successor to the 3-bit shift sampler in the odometer core. Each of CHANNELS serial inputs is shifted into a DEPTH-bit register during an armed capture window. At window end, all channels are snapshotted into a held output word with per-channel transition counts. A VALID/ACK handshake hands the word to the readout logic, with an optional continuous re-capture mode and overrun flag.

---
 rtl/shift_sample_capture.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/shift_sample_capture.sv
// Multi-channel serial sampler: shifts CHANNELS inputs over a DEPTH-sample window,
// snapshots them with per-channel transition counts, and hands off over VALID/ACK.

module ssc_lane #(
  parameter int DEPTH = 8,
  parameter int CW    = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             sin,
  input  logic             shift_en,
  input  logic             clr,
  input  logic             snap,
  output logic [DEPTH-1:0] data,
  output logic [CW-1:0]    trans
);
  logic [DEPTH-1:0] sr;
  logic [DEPTH-1:0] nxt;
  logic [CW-1:0]    tr;

  assign nxt = {sr[DEPTH-2:0], sin};

  // Count adjacent-bit changes in the word that the snapshot will capture.
  always_comb begin
    tr = '0;
    for (int i = 0; i < DEPTH-1; i++)
      tr = tr + CW'(nxt[i] ^ nxt[i+1]);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sr    <= '0;
      data  <= '0;
      trans <= '0;
    end else begin
      if (clr)           sr <= '0;
      else if (shift_en) sr <= nxt;
      if (snap) begin
        data  <= nxt;
        trans <= tr;
      end
    end
  end
endmodule

module shift_sample_capture #(
  parameter int DEPTH    = 8,
  parameter int CHANNELS = 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [CHANNELS-1:0]          SHIFT_IN,
  input  logic                         ARM,
  input  logic                         ABORT,
  input  logic                         CONT,
  input  logic                         ACK,
  output logic [CHANNELS*DEPTH-1:0]    DATA_OUT,
  output logic [CHANNELS*$clog2(DEPTH)-1:0] TRANS_OUT,
  output logic                         VALID,
  output logic                         BUSY,
  output logic                         OVERRUN
);
  localparam int CW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_HOLD} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          valid_n, ovr_n;
  logic          shift_en, clr, snap;

  logic [CHANNELS-1:0][DEPTH-1:0] data_a;
  logic [CHANNELS-1:0][CW-1:0]    trans_a;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    ssc_lane #(.DEPTH(DEPTH), .CW(CW)) u_lane (
      .CLK      (CLK),
      .RST      (RST),
      .sin      (SHIFT_IN[c]),
      .shift_en (shift_en),
      .clr      (clr),
      .snap     (snap),
      .data     (data_a[c]),
      .trans    (trans_a[c])
    );
  end

  assign DATA_OUT  = data_a;
  assign TRANS_OUT = trans_a;
  assign BUSY      = (state == S_FILL);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= S_IDLE;
      cnt     <= '0;
      VALID   <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      VALID   <= valid_n;
      OVERRUN <= ovr_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    valid_n  = VALID;
    ovr_n    = OVERRUN;
    shift_en = 1'b0;
    clr      = 1'b0;
    snap     = 1'b0;
    if (ABORT) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      clr     = 1'b1;
      valid_n = 1'b0;
      ovr_n   = 1'b0;
    end else begin
      case (state)
        S_IDLE: if (ARM) begin
          state_n = S_FILL;
          cnt_n   = '0;
          clr     = 1'b1;
        end
        S_FILL: begin
          shift_en = 1'b1;
          cnt_n    = cnt + CW'(1);
          if (ACK) valid_n = 1'b0;
          if (cnt == CW'(DEPTH-1)) begin
            // An ACK on the snapshot edge consumes the old word, so no overrun.
            snap    = 1'b1;
            valid_n = 1'b1;
            cnt_n   = '0;
            if (VALID && !ACK) ovr_n = 1'b1;
            if (CONT) clr = 1'b1;
            else      state_n = S_HOLD;
          end
        end
        S_HOLD: if (ACK) begin
          state_n = S_IDLE;
          valid_n = 1'b0;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end
endmodule
